if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the word-addressed PC and selects the next PC among sequential, branch and jump targets. Drives a request/ready handshake to instruction memory. Presents `if_ins` / `PC_plus_4` for the IF/ID register to capture, and honours the same `hazard`, `if_flush` and `id_Jump` controls that register uses.

## Interface
- `RESET_PC`, default 30'h0000_0000: word address `[31:2]` loaded on reset.
- `Clk`  in  1: single clock, rising edge.
- `Rst_n`  in  1: asynchronous, active-low reset.
- `hazard`  in  1: load-use stall; hold PC and hold the presented instruction.
- `if_flush`  in  1: taken branch resolved downstream; redirect to `branch_target`.
- `branch_target`  in  30: branch target word address `[31:2]`.
- `id_Jump`  in  1: jump decoded in ID; redirect to `jump_target`.
- `jump_target`  in  30: jump target word address `[31:2]`.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  30: fetch word address; equals the PC.
- `imem_ready`  in  1: memory returns `imem_rdata` this cycle for the current request.
- `imem_rdata`  in  32: instruction word.
- `if_ins`  out  32: instruction presented to IF/ID; 32'd0 (NOP) when none is valid.
- `PC_plus_4`  out  30: PC + 1 (word units) of the presented instruction.
- `if_stall`  out  1: high when `if_ins` is a NOP bubble caused by memory latency.

## Operation
- States: `REQ`, `HOLD`, `DROP`.
- Redirect: `if_flush` has priority over `id_Jump`, because the branch is older. The selected target is `tgt`.
- `REQ`:
  - `imem_req`=1 and `imem_addr`=PC.
  - If `imem_ready`, then `if_ins`=`imem_rdata`; otherwise `if_ins`=0 and `if_stall`=1.
  - Redirect with `imem_ready`, or with no request pending: PC←`tgt`, stay in `REQ`.
  - Redirect with `imem_req` && !`imem_ready`: latch `tgt` into `pend_pc` and go to `DROP`.
  - No redirect, `imem_ready`, !`hazard`: PC←PC+1.
  - No redirect, `imem_ready`, `hazard`: copy `imem_rdata` into `hold_ins` and go to `HOLD`. PC is unchanged.
  - No redirect, !`imem_ready`: no state change.
- `HOLD`:
  - `imem_req`=0 and `if_ins`=`hold_ins`.
  - Redirect: discard `hold_ins`, PC←`tgt`, go to `REQ`.
  - !`hazard`: PC←PC+1, go to `REQ`.
  - Otherwise stay in `HOLD`.
- `DROP`:
  - `imem_req`=1 and `imem_addr` stays at the old PC. A request, once issued, is never withdrawn or changed before `imem_ready`.
  - `if_ins`=0.
  - A further redirect overwrites `pend_pc` (flush priority still applies).
  - On `imem_ready`: data is discarded, PC←`pend_pc` (or the new `tgt` if a redirect arrives the same cycle), go to `REQ`.
- `PC_plus_4` = PC+1 in every state. Arithmetic is 30-bit and wraps 30'h3FFF_FFFF→0 silently.
- Redirect beats `hazard` in every state, matching IF/ID flush priority.

## Timing
- Reset values (async assert): PC=`RESET_PC`, state=`REQ`, `hold_ins`=0, `pend_pc`=0. Outputs during reset: `imem_req`=1, `imem_addr`=`RESET_PC`, `if_ins`=0 (no ready), `PC_plus_4`=`RESET_PC`+1, `if_stall`=1.
- Zero-wait memory (`imem_ready` same cycle): one instruction per cycle. The instruction at PC is presented in the cycle PC is driven; IF/ID captures it at the next edge.
- Each memory wait cycle produces one NOP bubble.
- A redirect takes effect at the next edge: the first target instruction is presented the cycle after the redirect (zero-wait memory).
- Reset asserted mid-`DROP` or mid-`HOLD`: return immediately to reset state. The pending memory transaction is abandoned; the memory side is reset by the same `Rst_n`.

## Structure
- Shared pipeline package:
  - state encoding `fetch_state_t` {`REQ`, `HOLD`, `DROP`}.
  - `NOP_INS` = 32'd0.
  - default `RESET_PC`.
- One natural sub-module: `pc_next_sel`, a combinational priority mux (flush > jump > sequential > hold). The FSM, PC register, `hold_ins` and `pend_pc` stay in `if_fetch`.

## Test plan
- Reset release with `RESET_PC`=0 and zero-wait memory: `imem_addr` is 0,1,2,3 on consecutive cycles; `PC_plus_4` is 1,2,3,4.
- `hazard` high for 2 cycles while fetching addr 5: `if_ins` holds the word from addr 5 for 3 cycles with `imem_req`=0 in `HOLD`. The next request is addr 6.
- `if_flush` and `id_Jump` in the same cycle (`branch_target`=0x40, `jump_target`=0x80): the next `imem_addr` is 0x40.
- `id_Jump` (target 0x20) while addr 9 is waiting with 3 wait states: `imem_addr` stays 9 until ready, `if_ins`=0 throughout, then `imem_addr` is 0x20. The word from addr 9 is never presented.
- `hazard` and `if_flush` together in `HOLD`: the held instruction is dropped, the next `imem_addr` is `branch_target`, and the state is `REQ`.
- PC=30'h3FFF_FFFF with zero-wait memory: `PC_plus_4`=0 and the next `imem_addr`=0. Assert `Rst_n` low mid-wait: `imem_addr` becomes `RESET_PC` asynchronously.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned INS_W  = 32;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      HOLD = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [INS_W-1:0]  NOP_INS          = INS_W'(0);
   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = ADDR_W'(0);

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: flush > jump > sequential > hold.
module pc_next_sel
   import if_fetch_pkg::*;
(
   input  logic              flush_i,
   input  logic              jump_i,
   input  logic              seq_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   input  logic [ADDR_W-1:0] jump_target_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              redirect_o,
   output logic [ADDR_W-1:0] tgt_o,
   output logic [ADDR_W-1:0] next_pc_o
);

   always_comb begin
      redirect_o = flush_i | jump_i;
      // The branch is older than the jump, so it wins.
      tgt_o      = flush_i ? branch_target_i : jump_target_i;
      next_pc_o  = pc_i;
      if (redirect_o) begin
         next_pc_o = tgt_o;
      end else if (seq_i) begin
         next_pc_o = pc_i + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory
// and presents the fetched word to the IF/ID register.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              hazard,
   input  logic              if_flush,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              id_Jump,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [INS_W-1:0]  imem_rdata,
   output logic [INS_W-1:0]  if_ins,
   output logic [ADDR_W-1:0] PC_plus_4,
   output logic              if_stall
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic [INS_W-1:0]  hold_ins_q, hold_ins_d;

   logic              redirect;
   logic [ADDR_W-1:0] tgt;
   logic [ADDR_W-1:0] next_pc;

   pc_next_sel u_pc_next_sel (
      .flush_i         (if_flush),
      .jump_i          (id_Jump),
      .seq_i           (~hazard),
      .branch_target_i (branch_target),
      .jump_target_i   (jump_target),
      .pc_i            (pc_q),
      .redirect_o      (redirect),
      .tgt_o           (tgt),
      .next_pc_o       (next_pc)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= REQ;
         pc_q       <= RESET_PC;
         pend_pc_q  <= ADDR_W'(0);
         hold_ins_q <= NOP_INS;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         hold_ins_q <= hold_ins_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      hold_ins_d = hold_ins_q;
      imem_req   = 1'b1;
      if_ins     = NOP_INS;
      if_stall   = 1'b0;

      unique case (state_q)
         REQ: begin
            if (imem_ready) begin
               if_ins = imem_rdata;
               pc_d   = next_pc;
               if (!redirect && hazard) begin
                  hold_ins_d = imem_rdata;
                  state_d    = HOLD;
               end
            end else begin
               if_stall = 1'b1;
               // An issued request must complete before the PC can move.
               if (redirect) begin
                  pend_pc_d = tgt;
                  state_d   = DROP;
               end
            end
         end
         HOLD: begin
            imem_req = 1'b0;
            if_ins   = hold_ins_q;
            pc_d     = next_pc;
            if (redirect || !hazard) begin
               state_d = REQ;
            end
         end
         DROP: begin
            if (imem_ready) begin
               pc_d    = redirect ? tgt : pend_pc_q;
               state_d = REQ;
            end else if (redirect) begin
               pend_pc_d = tgt;
            end
         end
         default: begin
            state_d = REQ;
         end
      endcase
   end

   assign imem_addr = pc_q;
   assign PC_plus_4 = pc_q + ADDR_W'(1);

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a behavioural instruction memory.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hazard = 1'b0;
   logic        if_flush = 1'b0;
   logic [29:0] branch_target = 30'd0;
   logic        id_Jump = 1'b0;
   logic [29:0] jump_target = 30'd0;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata;
   logic [31:0] if_ins;
   logic [29:0] PC_plus_4;
   logic        if_stall;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Memory returns a recognisable word per address: 0xC000_0000 | addr.
   always_comb imem_rdata = 32'hC000_0000 | 32'(imem_addr);

   if_fetch #(.RESET_PC(30'h0)) dut (
      .Clk           (clk),
      .Rst_n         (rst_n),
      .hazard        (hazard),
      .if_flush      (if_flush),
      .branch_target (branch_target),
      .id_Jump       (id_Jump),
      .jump_target   (jump_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .if_ins        (if_ins),
      .PC_plus_4     (PC_plus_4),
      .if_stall      (if_stall)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state, memory not ready.
      #2;
      check("rst_req",   32'(imem_req),  32'd1);
      check("rst_addr",  32'(imem_addr), 32'd0);
      check("rst_ins",   if_ins,         32'd0);
      check("rst_p4",    32'(PC_plus_4), 32'd1);
      check("rst_stall", 32'(if_stall),  32'd1);

      @(negedge clk);
      rst_n = 1'b1;
      imem_ready = 1'b1;
      #1;
      // Sequential zero-wait fetch.
      for (int i = 0; i < 4; i++) begin
         check("seq_addr", 32'(imem_addr), 32'(i));
         check("seq_p4",   32'(PC_plus_4), 32'(i + 1));
         check("seq_ins",  if_ins,         32'hC000_0000 | 32'(i));
         tick();
      end
      tick();
      check("pre_hz_addr", 32'(imem_addr), 32'd5);

      // Hazard for two cycles on addr 5.
      hazard = 1'b1;
      #1;
      check("hz0_ins", if_ins, 32'hC000_0005);
      tick();
      #1;
      check("hz1_req", 32'(imem_req), 32'd0);
      check("hz1_ins", if_ins,        32'hC000_0005);
      tick();
      hazard = 1'b0;
      #1;
      check("hz2_req",  32'(imem_req),  32'd0);
      check("hz2_ins",  if_ins,         32'hC000_0005);
      check("hz2_addr", 32'(imem_addr), 32'd5);
      tick();
      #1;
      check("post_hz_addr", 32'(imem_addr), 32'd6);
      check("post_hz_req",  32'(imem_req),  32'd1);

      // Flush and jump together: flush wins.
      if_flush = 1'b1; branch_target = 30'h40;
      id_Jump = 1'b1;  jump_target = 30'h80;
      tick();
      if_flush = 1'b0; id_Jump = 1'b0;
      #1;
      check("prio_addr", 32'(imem_addr), 32'h40);
      check("prio_ins",  if_ins,         32'hC000_0040);

      // Branch to 9, then jump to 0x20 while 9 waits three cycles.
      if_flush = 1'b1; branch_target = 30'd9;
      tick();
      if_flush = 1'b0;
      imem_ready = 1'b0;
      id_Jump = 1'b1; jump_target = 30'h20;
      #1;
      check("w0_addr",  32'(imem_addr), 32'd9);
      check("w0_ins",   if_ins,         32'd0);
      check("w0_stall", 32'(if_stall),  32'd1);
      tick();
      id_Jump = 1'b0;
      #1;
      check("w1_addr", 32'(imem_addr), 32'd9);
      check("w1_req",  32'(imem_req),  32'd1);
      check("w1_ins",  if_ins,         32'd0);
      tick();
      #1;
      check("w2_addr", 32'(imem_addr), 32'd9);
      check("w2_ins",  if_ins,         32'd0);
      tick();
      imem_ready = 1'b1;
      #1;
      check("w3_addr", 32'(imem_addr), 32'd9);
      check("w3_ins",  if_ins,         32'd0);
      tick();
      #1;
      check("jmp_addr", 32'(imem_addr), 32'h20);
      check("jmp_ins",  if_ins,         32'hC000_0020);

      // Hazard into HOLD, then hazard with flush.
      hazard = 1'b1;
      tick();
      #1;
      check("hold_req", 32'(imem_req), 32'd0);
      check("hold_ins", if_ins,        32'hC000_0020);
      if_flush = 1'b1; branch_target = 30'h33;
      tick();
      if_flush = 1'b0; hazard = 1'b0;
      #1;
      check("hf_addr", 32'(imem_addr), 32'h33);
      check("hf_req",  32'(imem_req),  32'd1);
      check("hf_ins",  if_ins,         32'hC000_0033);

      // PC wrap at the top of the address space.
      if_flush = 1'b1; branch_target = 30'h3FFF_FFFF;
      tick();
      if_flush = 1'b0;
      #1;
      check("wrap_addr", 32'(imem_addr), 32'h3FFF_FFFF);
      check("wrap_p4",   32'(PC_plus_4), 32'd0);
      tick();
      #1;
      check("wrap_next", 32'(imem_addr), 32'd0);
      tick();
      imem_ready = 1'b0;
      #1;
      check("mw_addr",  32'(imem_addr), 32'd1);
      check("mw_stall", 32'(if_stall),  32'd1);

      // Asynchronous reset in the middle of a wait.
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_addr", 32'(imem_addr), 32'd0);
      check("arst_p4",   32'(PC_plus_4), 32'd1);
      check("arst_ins",  if_ins,         32'd0);
      check("arst_req",  32'(imem_req),  32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
